// File: rtl/mac_accum_seq_if.sv
// mac_accum_seq_if: operand-in / result-out handshake bundle for mac_accum_seq.
//   in_valid/in_ready/in_a/in_b       : operand beat stream (source -> engine)
//   out_valid/out_ready/out_acc/out_ovf: frame result stream (engine -> sink)
// Modports: master = source/sink side (testbench, upstream logic),
//           slave  = engine side.
interface mac_accum_seq_if #(
   parameter int A_W   = 2,
   parameter int B_W   = 3,
   parameter int ACC_W = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [A_W-1:0]   in_a;
   logic [B_W-1:0]   in_b;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_acc, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_acc, out_ovf
   );
endinterface

// File: rtl/mac_accum_seq.sv
// mac_accum_seq: sequential multiply-accumulate frame engine.
// Accepts N_TERMS unsigned (a,b) beats, sums a*b into a registered accumulator,
// then holds the frame sum on the output handshake until it is taken.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   sync_clr : synchronous frame abort, highest priority
//   bus      : mac_accum_seq_if.slave (operand in / result out handshakes)
// Build option: MAC_SATURATE_EN defined -> accumulator clamps at 2^ACC_W-1 on
// overflow for the rest of the frame; undefined -> accumulator wraps.
// out_ovf flags overflow in both builds.
module mac_accum_seq #(
   parameter int A_W     = 2,
   parameter int B_W     = 3,
   parameter int ACC_W   = 6,
   parameter int N_TERMS = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sync_clr,
   mac_accum_seq_if.slave bus
);
   localparam int P_W   = A_W + B_W;
   // Sum wide enough to hold both a full product and an ACC_W carry-out,
   // so "product too wide on its own" and "carry out" are one test.
   localparam int S_W   = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
   localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] acc;
   logic             ovf;

   logic             accept;
   logic             first;
   logic             last;
   logic [P_W-1:0]   prod;
   logic [ACC_W-1:0] base;
   logic [S_W-1:0]   sum;
   logic             beat_ovf;
   logic             ovf_nxt;
   logic [ACC_W-1:0] acc_nxt;

   assign accept = bus.in_valid & bus.in_ready;
   assign first  = (cnt == '0);
   assign last   = (cnt == CNT_W'(N_TERMS - 1));

   assign prod     = P_W'(bus.in_a) * P_W'(bus.in_b);
   // First beat of a frame reloads instead of adding.
   assign base     = first ? '0 : acc;
   assign sum      = S_W'(base) + S_W'(prod);
   assign beat_ovf = |sum[S_W-1:ACC_W];
   assign ovf_nxt  = beat_ovf | (first ? 1'b0 : ovf);

`ifdef MAC_SATURATE_EN
   // Sticky ovf keeps the clamp for the remainder of the frame.
   assign acc_nxt = ovf_nxt ? '1 : sum[ACC_W-1:0];
`else
   assign acc_nxt = sum[ACC_W-1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
         cnt   <= '0;
         acc   <= '0;
         ovf   <= 1'b0;
      end else if (sync_clr) begin
         state <= ACCUM;
         cnt   <= '0;
         acc   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= acc_nxt;
                  ovf <= ovf_nxt;
                  if (last) begin
                     cnt   <= '0;
                     state <= HOLD;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               // No same-cycle handoff: beats resume the cycle after release.
               if (bus.out_ready) state <= ACCUM;
            end
            default: state <= ACCUM;
         endcase
      end
   end

   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == HOLD);
   assign bus.out_acc   = acc;
   assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_mac_accum_seq.sv
// tb_mac_accum_seq: directed-vector bench with an expected-result queue.
// Stimulus pushes the hand-computed frame result before driving the beats;
// an independent monitor pops and compares on every output handshake.
module tb_mac_accum_seq;
   localparam int A_W = 2, B_W = 3, ACC_W = 6, N_TERMS = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic sync_clr;

   int checks = 0;
   int errors = 0;

   logic [ACC_W:0] exp_q[$];   // {ovf, acc}

   mac_accum_seq_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus ();

   mac_accum_seq #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .N_TERMS(N_TERMS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync_clr (sync_clr),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [ACC_W:0] mk(input int ovf, input int acc);
      logic [ACC_W:0] r;
      r = {ovf[0], acc[ACC_W-1:0]};
      return r;
   endfunction

   // Monitor: inputs change #1 after posedge, so the negedge view matches
   // what the next posedge sees.
   always @(negedge clk) begin
      logic [ACC_W:0] e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got acc=%0d ovf=%0d with nothing expected",
                     bus.out_acc, bus.out_ovf);
         end else begin
            e = exp_q.pop_front();
            chk("result_acc", int'(bus.out_acc), int'(e[ACC_W-1:0]));
            chk("result_ovf", int'(bus.out_ovf), int'(e[ACC_W]));
         end
      end
   end

   task automatic send(input int a, input int b);
      int n;
      bus.in_valid = 1'b1;
      bus.in_a     = A_W'(a);
      bus.in_b     = B_W'(b);
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      sync_clr      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_acc",   int'(bus.out_acc), 0);
      chk("rst_out_ovf",   int'(bus.out_ovf), 0);
      rst_n = 1'b1;

      // T1: reset mid-frame (cnt=2), then a full frame is still required
      send(1, 1);
      send(2, 3);
      chk("t1_partial_acc", int'(bus.out_acc), 7);
      rst_n = 1'b0;
      #1;
      chk("t1_in_ready",  int'(bus.in_ready), 1);
      chk("t1_out_valid", int'(bus.out_valid), 0);
      chk("t1_out_acc",   int'(bus.out_acc), 0);
      chk("t1_out_ovf",   int'(bus.out_ovf), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.push_back(mk(0, 5));
      send(1, 1);
      send(1, 1);
      send(1, 1);
      repeat (3) @(negedge clk);
      chk("t1_no_early_valid", int'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      send(1, 2);
      wait_drain();

      // T2: basic frame, latency of one cycle after last accept
      exp_q.push_back(mk(0, 11));
      send(1, 2);
      send(2, 3);
      send(3, 1);
      chk("t2_valid_before_last", int'(bus.out_valid), 0);
      send(0, 7);
      chk("t2_valid_latency", int'(bus.out_valid), 1);
      wait_drain();

      // T3: overflow, 4 x 21 = 84
`ifdef MAC_SATURATE_EN
      exp_q.push_back(mk(1, 63));
`else
      exp_q.push_back(mk(1, 20));
`endif
      repeat (4) send(3, 7);
      wait_drain();

      // T4: backpressure, 3+4+1+9 = 17
      bus.out_ready = 1'b0;
      exp_q.push_back(mk(0, 17));
      send(1, 3);
      send(2, 2);
      send(1, 1);
      send(3, 3);
      bus.in_valid = 1'b1;   // offered beat must not be consumed
      bus.in_a     = 2'd3;
      bus.in_b     = 3'd3;
      repeat (5) begin
         @(negedge clk);
         chk("t4_hold_valid", int'(bus.out_valid), 1);
         chk("t4_hold_acc",   int'(bus.out_acc), 17);
         chk("t4_in_ready",   int'(bus.in_ready), 0);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_release_in_ready", int'(bus.in_ready), 1);
      chk("t4_release_valid",    int'(bus.out_valid), 0);
      chk("t4_drained", exp_q.size(), 0);

      // T5: gapped beats, only accepted beats count
      exp_q.push_back(mk(0, 4));
      bus.in_a = 2'd1;
      bus.in_b = 3'd1;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = (i % 2 == 0);
         @(posedge clk);
         #1;
         if (i == 4) chk("t5_mid_valid", int'(bus.out_valid), 0);
      end
      bus.in_valid = 1'b0;
      wait_drain();

      // T6: sync_clr on the 3rd accepted beat aborts the frame
      exp_q.push_back(mk(0, 16));
      send(1, 1);
      send(2, 1);
      bus.in_valid = 1'b1;
      bus.in_a     = 2'd3;
      bus.in_b     = 3'd2;
      sync_clr     = 1'b1;
      @(posedge clk);
      #1;
      sync_clr     = 1'b0;
      bus.in_valid = 1'b0;
      chk("t6_clr_acc",      int'(bus.out_acc), 0);
      chk("t6_clr_in_ready", int'(bus.in_ready), 1);
      repeat (4) send(2, 2);
      wait_drain();

      chk("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
